// File: rtl/mxv_pkg.sv
// Shared constants and helpers for the matrix-vector datapath.
// Shared by the lane FIFOs and the lane-select counter.
package mxv_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 8;
    localparam int LANES          = 4;

    // Smallest r with 2**r >= n; usable in parameter defaults.
    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mxv_lane_fifo_if.sv
// Handshake bundle between the lane-select counter / MAC stage and one lane FIFO.
// Optional sticky error flags are present when MXV_FIFO_ERR_FLAGS_EN is defined.
interface mxv_lane_fifo_if
    import mxv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ceil_log2(DEPTH)
);

    logic                  push;
    logic                  zero_fill;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
`ifdef MXV_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, zero_fill, data_in, pop,
        input  data_out, data_valid, count, empty, full, overflow, underflow
    );
    modport slave (
        input  push, zero_fill, data_in, pop,
        output data_out, data_valid, count, empty, full, overflow, underflow
    );
`else
    modport master (
        output push, zero_fill, data_in, pop,
        input  data_out, data_valid, count, empty, full
    );
    modport slave (
        input  push, zero_fill, data_in, pop,
        output data_out, data_valid, count, empty, full
    );
`endif

endinterface

// File: rtl/mxv_wrap_ptr.sv
// Wrapping FIFO pointer: increments on enable, wraps naturally at 2**ADDR_WIDTH.
module mxv_wrap_ptr #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mxv_lane_fifo.sv
// Per-lane input FIFO with zero-pad on write and a registered read port.
// Define MXV_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module mxv_lane_fifo
    import mxv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ceil_log2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    mxv_lane_fifo_if.slave    bus
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  empty;
    logic                  full;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  push_ok;
    logic                  pop_ok;

    // A full FIFO still takes a push when the same cycle frees the head slot.
    assign push_ok = bus.push && (!full || bus.pop);
    assign pop_ok  = bus.pop && !empty;

    mxv_wrap_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_ok),
        .ptr   (wr_ptr)
    );

    mxv_wrap_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_ok),
        .ptr   (rd_ptr)
    );

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == (ADDR_WIDTH+1)'(DEPTH));
        end
    end

    // Storage is never cleared; reset pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.zero_fill ? '0 : bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= pop_ok;
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
            end
        end
    end

    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.count      = count;
    assign bus.empty      = empty;
    assign bus.full       = full;

`ifdef MXV_FIFO_ERR_FLAGS_EN
    logic overflow;
    logic underflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.push && full && !bus.pop) overflow  <= 1'b1;
            if (bus.pop && empty)             underflow <= 1'b1;
        end
    end

    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
`endif

endmodule

// File: tb/tb_mxv_lane_fifo.sv
// Self-checking bench for mxv_lane_fifo: directed scenarios plus random traffic vs a queue model.
module tb_mxv_lane_fifo;

    localparam int DW = 8;
    localparam int DP = 8;

    logic clk;
    logic reset;

    mxv_lane_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    mxv_lane_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain queue plus expected registered outputs.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_out;
    logic          exp_valid;
    logic          exp_ovf;
    logic          exp_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_valid"}, 32'(bus.data_valid), 32'(exp_valid));
        if (exp_valid) check({tag, ".data_out"}, 32'(bus.data_out), 32'(exp_out));
        check({tag, ".count"}, 32'(bus.count), 32'(model_q.size()));
        check({tag, ".empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
        check({tag, ".full"}, 32'(bus.full), 32'(model_q.size() == DP));
`ifdef MXV_FIFO_ERR_FLAGS_EN
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(exp_udf));
`endif
    endtask

    // One clock of traffic, model update, then checks 1ns after the edge.
    task automatic step(input string tag, input logic p, input logic zf,
                        input logic [DW-1:0] d, input logic r);
        bit take_push;
        bit take_pop;
        bus.push      = p;
        bus.zero_fill = zf;
        bus.data_in   = d;
        bus.pop       = r;
        take_pop  = r && (model_q.size() > 0);
        take_push = p && ((model_q.size() < DP) || r);
        if (p && (model_q.size() == DP) && !r) exp_ovf = 1'b1;
        if (r && (model_q.size() == 0))        exp_udf = 1'b1;
        exp_valid = take_pop;
        if (take_pop)  exp_out = model_q.pop_front();
        if (take_push) model_q.push_back(zf ? '0 : d);
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        bus.data_in = 8'hEE;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        model_q.delete();
        exp_out   = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        check_all(tag);
        check({tag, ".data_out"}, 32'(bus.data_out), 32'h0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.push      = 1'b0;
        bus.zero_fill = 1'b0;
        bus.data_in   = '0;
        bus.pop       = 1'b0;
        exp_out = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("rst0");

        // Basic ordering
        step("p11", 1, 0, 8'h11, 0);
        step("p22", 1, 0, 8'h22, 0);
        step("p33", 1, 0, 8'h33, 0);
        for (int i = 0; i < 3; i++) step("pop3", 0, 0, '0, 1);
        check("order.last", 32'(bus.data_out), 32'h33);

        // Zero fill, and zero_fill without push
        step("zf_nopush", 0, 1, 8'h77, 0);
        step("zf_push", 1, 1, 8'h5A, 0);
        step("zf_pop", 0, 0, '0, 1);
        check("zf.value", 32'(bus.data_out), 32'h00);

        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) step("fill", 1, 0, 8'(i), 0);
        step("ovf", 1, 0, 8'h09, 0);
        for (int i = 0; i < 8; i++) step("drain", 0, 0, '0, 1);
        step("pop_empty", 0, 0, '0, 1);
        check("drain.hold", 32'(bus.data_out), 32'h08);

        // Simultaneous push+pop at full
        for (int i = 1; i <= 8; i++) step("fill2", 1, 0, 8'(i), 0);
        step("full_pp", 1, 0, 8'hAA, 1);
        check("full_pp.head", 32'(bus.data_out), 32'h01);
        for (int i = 0; i < 8; i++) step("drain2", 0, 0, '0, 1);
        check("full_pp.tail", 32'(bus.data_out), 32'hAA);

        // Simultaneous push+pop at empty
        step("empty_pp", 1, 0, 8'h7E, 1);
        step("empty_pp.pop", 0, 0, '0, 1);
        check("empty_pp.value", 32'(bus.data_out), 32'h7E);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) step("pre_rst", 1, 0, 8'h40 + 8'(i), 0);
        step("pre_rst.pop", 0, 0, '0, 1);
        step("pre_rst.pop", 0, 0, '0, 1);
        do_reset("rst_mid");
        step("post_rst.push", 1, 0, 8'hC3, 0);
        step("post_rst.pop", 0, 0, '0, 1);
        check("post_rst.value", 32'(bus.data_out), 32'hC3);

        // Pointer wrap with interleaved pairs
        step("wrap.seed", 1, 0, 8'hF0, 0);
        for (int i = 0; i < 20; i++) begin
            step("wrap.push", 1, 0, 8'(8'h80 + i), 0);
            step("wrap.pop", 0, 0, '0, 1);
        end

        // Random traffic
        do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 9) == 0),
                 8'($urandom), 1'($urandom_range(0, 99) < 45));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
